hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Parametrised load-use / control hazard unit for the 5-stage RISC-V pipeline, in ID/EX control.
//  Detects load-use hazards (ID source regs vs load rd in EX) and stalls for a configurable
//  load latency. Freezes the whole pipeline while data memory is busy. Flushes wrong-path
//  instructions on a taken branch/jump resolved in EX. Replaces the single-cycle combinational
//  detector: x0 is excluded, rs usage is qualified, control enables are active-high.
// PARAMETERS
//  REG_AW    5  register address width
//  LOAD_LAT  1  stall cycles per load-use hazard (>=1)
//  PERF_W   32  width of perf counters (used only with HAZARD_PERF_EN)
// PORTS
//  clk              in   1       pipeline clock
//  reset            in   1       asynchronous, active-high reset
//  ex_is_load       in   1       instruction in ID/EX is a load
//  ex_rd            in   REG_AW  destination register of ID/EX instruction
//  id_rs1           in   REG_AW  rs1 of IF/ID instruction
//  id_rs2           in   REG_AW  rs2 of IF/ID instruction
//  id_uses_rs1      in   1       IF/ID instruction reads rs1
//  id_uses_rs2      in   1       IF/ID instruction reads rs2
//  ex_redirect      in   1       taken branch/jump resolved in EX this cycle
//  mem_busy         in   1       data memory not ready; pipeline must freeze
//  pc_write         out  1       1 = PC updates
//  ifid_write       out  1       1 = IF/ID register loads
//  idex_bubble      out  1       1 = ID/EX loads NOP controls
//  ifid_flush       out  1       1 = IF/ID cleared to NOP
//  pipe_freeze      out  1       1 = ID/EX, EX/MEM, MEM/WB hold
//  stall_cnt        out  PERF_W  load-use stall cycles (HAZARD_PERF_EN only)
//  flush_cnt        out  PERF_W  redirect flushes (HAZARD_PERF_EN only)
// BEHAVIOUR
//  - hit = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  - FSM (hazard_pkg::hz_state_t): IDLE, STALL. Down-counter cnt, width $clog2(LOAD_LAT+1).
//  - All outputs are combinational from state/cnt and inputs, so there is zero-cycle response.
//  - Priority per cycle: reset > mem_busy > ex_redirect > load-use stall > normal.
//  - mem_busy=1: pc_write=0, ifid_write=0, pipe_freeze=1, bubble=0, flush=0. State and cnt hold.
//  - ex_redirect=1 (and !mem_busy): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
//    The FSM goes to IDLE and cnt=0. Any concurrent hit is discarded (wrong path).
//  - IDLE & hit: pc_write=0, ifid_write=0, idex_bubble=1.
//    If LOAD_LAT>1, next state is STALL with cnt=LOAD_LAT-1. Otherwise stay IDLE.
//  - STALL: same stall outputs, and hit is not re-evaluated. cnt decrements each
//    non-frozen cycle. When cnt==1, next state is IDLE.
//  - Normal: pc_write=1, ifid_write=1, all other outputs 0.
//  - Reset (async assert, sync-style release): state=IDLE, cnt=0.
//    Outputs during reset: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_freeze=0.
//    Perf counters are cleared to 0. Reset mid-STALL abandons the stall.
//  - A bubble never counts as a load because EX of a bubble has ex_is_load=0.
//    Back-to-back loads therefore re-detect correctly.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: stall_cnt increments on every cycle with a load-use stall output.
//    flush_cnt increments on every cycle with ifid_flush=1. Both wrap at 2^PERF_W, no saturation.
//    Neither counts during reset or mem_busy.
//  - Not defined: the stall_cnt/flush_cnt ports and their logic are absent.
// STRUCTURE
//  - hazard_pkg: hz_state_t enum {IDLE, STALL}, REG_X0 = '0 constant, NOP control constants.
//  - One sub-module, hazard_cmp: pure comparator producing hit, for reuse by the forwarding unit.
//  - Top module holds the FSM, the counter, output decode and the optional perf counters.
// TESTING
//  1. LOAD_LAT=1: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1
//     -> one cycle pc_write=0/ifid_write=0/bubble=1, then normal.
//  2. ex_rd=0, id_rs1=0, load -> no stall.
//     id_uses_rs2=0 with id_rs2=ex_rd=7 -> no stall.
//  3. LOAD_LAT=3, hit on rs2=9 -> exactly 3 stall cycles.
//     With mem_busy=1 for 2 cycles in the middle -> 5 total hold cycles, cnt frozen, freeze=1 for 2.
//  4. Hit and ex_redirect in the same cycle -> ifid_flush=1, bubble=1, pc_write=1.
//     Next cycle normal, state IDLE.
//  5. Assert reset in the 2nd STALL cycle (LOAD_LAT=3) -> reset outputs immediately.
//     After release: IDLE, normal outputs, counters 0.
//  6. HAZARD_PERF_EN: 4 load-use stalls (LAT=2) + 3 redirects -> stall_cnt=8, flush_cnt=3.
//     Preload PERF_W=4 at 15 + 1 stall -> wraps to 0.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg: shared FSM state, x0 constant and pipeline control encodings for hazard_stall_unit.
package hazard_pkg;
  typedef enum logic {IDLE, STALL} hz_state_t;
  localparam int REG_X0 = 0;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic pipe_freeze;
  } hz_ctrl_t;
  localparam hz_ctrl_t CTRL_RUN    = 5'b11000;
  localparam hz_ctrl_t CTRL_STALL  = 5'b00100;
  localparam hz_ctrl_t CTRL_FREEZE = 5'b00001;
  localparam hz_ctrl_t CTRL_FLUSH  = 5'b11110;
  localparam hz_ctrl_t CTRL_RESET  = 5'b00100;
endpackage

// File: rtl/hazard_stall_unit_cmp.sv
// hazard_cmp: load-use comparator, x0 excluded and source use qualified; shared with forwarding.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  output logic              hit_o
);
  assign hit_o = ex_is_load_i && (ex_rd_i != REG_AW'(REG_X0)) &&
                 ((id_uses_rs1_i && id_rs1_i == ex_rd_i) || (id_uses_rs2_i && id_rs2_i == ex_rd_i));
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall FSM, memory freeze and redirect flush for the 5-stage pipeline.
// Optional perf counters (stall_cnt/flush_cnt) are built only when HAZARD_PERF_EN is defined.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pipe_freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);
  localparam int CW = $clog2(LOAD_LAT + 1);
  hz_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hit, stall;
  hz_ctrl_t ctrl;
  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_uses_rs1_i(id_uses_rs1),
    .id_uses_rs2_i(id_uses_rs2),
    .hit_o        (hit)
  );
  // In STALL the hit is not re-evaluated: the load is already past EX.
  assign stall = !reset && !mem_busy && !ex_redirect && (state_q == STALL || hit);
  assign ctrl = reset ? CTRL_RESET : mem_busy ? CTRL_FREEZE : ex_redirect ? CTRL_FLUSH :
                stall ? CTRL_STALL : CTRL_RUN;
  assign {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze} = ctrl;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_redirect && !mem_busy) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (stall && state_q == STALL) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == CW'(1)) ? IDLE : STALL;
    end else if (stall && LOAD_LAT > 1) begin
      state_d = STALL;
      cnt_d   = CW'(LOAD_LAT - 1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 1'b1;
      if (ctrl.ifid_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboarded directed test of hazard_stall_unit at LOAD_LAT 1, 2 and 3.
module tb_hazard_stall_unit;
  localparam logic [4:0] R = 5'b11000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] F = 5'b00001;
  localparam logic [4:0] X = 5'b11110;
  localparam logic [4:0] Z = 5'b00100;
  typedef struct {
    int         sel;
    logic [4:0] e;
    bit         chk;
    logic [3:0] es;
    logic [3:0] ef;
    string      nm;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ex_is_load = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;
  logic [4:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic [4:0] o1, o2, o3;
  logic [3:0] sc1, sc2, sc3, fc1, fc2, fc3;
  always #5 clk = ~clk;
`ifdef HAZARD_PERF_EN
  `define PERF_PORTS(s, f) , .stall_cnt(s), .flush_cnt(f)
`else
  `define PERF_PORTS(s, f)
  assign {sc1, sc2, sc3, fc1, fc2, fc3} = '0;
`endif
  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(4)) u1 (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(o1[4]), .ifid_write(o1[3]), .idex_bubble(o1[2]), .ifid_flush(o1[1]), .pipe_freeze(o1[0])
    `PERF_PORTS(sc1, fc1));
  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(2), .PERF_W(4)) u2 (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(o2[4]), .ifid_write(o2[3]), .idex_bubble(o2[2]), .ifid_flush(o2[1]), .pipe_freeze(o2[0])
    `PERF_PORTS(sc2, fc2));
  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(4)) u3 (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(o3[4]), .ifid_write(o3[3]), .idex_bubble(o3[2]), .ifid_flush(o3[1]), .pipe_freeze(o3[0])
    `PERF_PORTS(sc3, fc3));
  task automatic go(input int sel, input logic rst, input logic ld, input logic [4:0] rd,
                    input logic [4:0] r1, input logic [4:0] r2, input logic u1v, input logic u2v,
                    input logic rdr, input logic bsy, input logic [4:0] e, input string nm,
                    input bit chk = 1'b0, input logic [3:0] es = '0, input logic [3:0] ef = '0);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    id_uses_rs1 = u1v; id_uses_rs2 = u2v; ex_redirect = rdr; mem_busy = bsy;
    x.sel = sel; x.e = e; x.chk = chk; x.es = es; x.ef = ef; x.nm = nm;
    q.push_back(x);
  endtask
  task automatic idle(input int sel, input logic [4:0] e, input string nm,
                      input bit chk = 1'b0, input logic [3:0] es = '0, input logic [3:0] ef = '0);
    go(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, nm, chk, es, ef);
  endtask
  task automatic rst(input int sel);
    go(sel, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z, "reset_out");
  endtask
  always @(negedge clk) begin
    exp_t x;
    logic [4:0] got;
    logic [3:0] gs, gf;
    if (q.size() > 0) begin
      x = q.pop_front();
      got = x.sel == 1 ? o1 : x.sel == 2 ? o2 : o3;
      n_chk++;
      if (got !== x.e) begin
        n_fail++;
        $display("FAIL %s (u%0d): got pc/ifw/bub/fl/frz=%b expected %b", x.nm, x.sel, got, x.e);
      end
      if (x.chk) begin
        gs = x.sel == 1 ? sc1 : x.sel == 2 ? sc2 : sc3;
        gf = x.sel == 1 ? fc1 : x.sel == 2 ? fc2 : fc3;
        n_chk++;
        if (gs !== x.es || gf !== x.ef) begin
          n_fail++;
          $display("FAIL %s_cnt (u%0d): got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   x.nm, x.sel, gs, gf, x.es, x.ef);
        end
      end
    end
  end
  initial begin
    // LOAD_LAT=1: single stall cycle, then the bubble reaches EX
    rst(1);
    go(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, S, "lat1_hit_rs1");
    idle(1, R, "lat1_after");
    // x0 and unused source operands never stall
    go(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, R, "x0_no_stall");
    go(1, 0, 1, 7, 0, 7, 0, 0, 0, 0, R, "rs2_unused");
    go(1, 0, 0, 7, 7, 0, 1, 0, 0, 0, R, "not_load");
    go(1, 0, 1, 7, 0, 7, 0, 1, 0, 0, S, "rs2_used");
    idle(1, R, "rs2_after");
    // LOAD_LAT=3: exactly three stall cycles
    rst(3);
    go(3, 0, 1, 9, 0, 9, 0, 1, 0, 0, S, "lat3_s1");
    idle(3, S, "lat3_s2");
    idle(3, S, "lat3_s3");
    idle(3, R, "lat3_done");
    // memory freeze in the middle of the stall holds the count
    go(3, 0, 1, 9, 0, 9, 0, 1, 0, 0, S, "busy_s1");
    idle(3, S, "busy_s2");
    go(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, F, "busy_f1");
    go(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, F, "busy_over_redirect");
    idle(3, S, "busy_s3");
    idle(3, R, "busy_done");
    // redirect beats a concurrent hit and cancels a running stall
    go(3, 0, 1, 9, 9, 0, 1, 0, 1, 0, X, "redirect_hit");
    idle(3, R, "redirect_after");
    go(3, 0, 1, 4, 4, 0, 1, 0, 0, 0, S, "pre_redir_stall");
    go(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, X, "redirect_in_stall");
    idle(3, R, "stall_abandoned");
    // reset in the second stall cycle
    go(3, 0, 1, 9, 0, 9, 0, 1, 0, 0, S, "rst_s1");
    rst(3);
    idle(3, R, "after_reset", 1'b1, 4'd0, 4'd0);
`ifdef HAZARD_PERF_EN
    rst(2);
    for (int i = 0; i < 4; i++) begin
      go(2, 0, 1, 3, 3, 0, 1, 0, 0, 0, S, "perf_s1");
      idle(2, S, "perf_s2");
    end
    for (int i = 0; i < 3; i++) go(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, X, "perf_redirect");
    go(2, 0, 1, 3, 3, 0, 1, 0, 0, 1, F, "perf_busy_nocount");
    idle(2, R, "perf_totals", 1'b1, 4'd8, 4'd3);
    rst(1);
    for (int i = 0; i < 15; i++) go(1, 0, 1, 6, 6, 0, 1, 0, 0, 0, S, "wrap_stall");
    idle(1, R, "wrap_at15", 1'b1, 4'd15, 4'd0);
    go(1, 0, 1, 6, 6, 0, 1, 0, 0, 0, S, "wrap_last");
    idle(1, R, "wrap_zero", 1'b1, 4'd0, 4'd0);
`endif
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
